// File: rtl/free_list_pkg.sv
// Shared sizing and types for the rename-stage free list of physical register tags.
package free_list_pkg;

  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int PR_W         = $clog2(NUM_PHYS_REG);
  localparam int IDX_W        = $clog2(FL_SIZE);
  // One extra pointer bit acts as a wrap flag so full and empty stay distinguishable.
  localparam int PTR_W        = IDX_W + 1;
  localparam int CNT_W        = $clog2(FL_SIZE + 1);

  typedef logic [PR_W-1:0]  phys_reg_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam phys_reg_t DUMMY_REG = '0;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: dispatch pops the head, retire pushes stale tags.
// Optional head-pointer snapshot/recovery is built when FL_BRANCH_RECOVERY_EN is defined.
module free_list
  import free_list_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      enable,
  input  logic      dispatch_en,
  input  logic      retire_en,
  input  phys_reg_t retire_reg,
`ifdef FL_BRANCH_RECOVERY_EN
  input  logic      branch_snapshot,
  input  logic      branch_recover,
`endif
  output phys_reg_t free_reg_out,
  output logic      free_reg_valid,
  output cnt_t      free_cnt,
  output logic      empty,
  output logic      full
);

  phys_reg_t entries [FL_SIZE];
  ptr_t      head;
  ptr_t      tail;
  ptr_t      head_next;
  logic      pop;
  logic      push;

  assign free_cnt       = cnt_t'(tail - head);
  assign empty          = (free_cnt == '0);
  assign full           = (free_cnt == cnt_t'(FL_SIZE));
  assign free_reg_valid = !empty;
  assign free_reg_out   = entries[head[IDX_W-1:0]];

  // A pop never bypasses a same-cycle push: an empty list stays empty this cycle.
  assign pop  = enable && dispatch_en && !empty;
  assign push = enable && retire_en && !full;

`ifdef FL_BRANCH_RECOVERY_EN
  ptr_t snap_head;
  logic recover;
  logic take_snapshot;

  assign recover       = enable && branch_recover;
  assign take_snapshot = enable && branch_snapshot && !branch_recover;

  always_comb begin
    head_next = head;
    if (recover)
      head_next = snap_head;
    else if (pop)
      head_next = head + ptr_t'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      snap_head <= '0;
    else if (take_snapshot)
      snap_head <= pop ? head + ptr_t'(1) : head;
  end
`else
  always_comb begin
    head_next = head;
    if (pop)
      head_next = head + ptr_t'(1);
  end
`endif

  // After reset every non-architectural tag is free, so the list starts full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= ptr_t'(FL_SIZE);
      for (int i = 0; i < FL_SIZE; i++)
        entries[i] <= phys_reg_t'(NUM_ARCH_REG + i);
    end else begin
      head <= head_next;
      if (push) begin
        entries[tail[IDX_W-1:0]] <= retire_reg;
        tail <= tail + ptr_t'(1);
      end
    end
  end

`ifdef DEBUG
  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (reset) !(enable && retire_en && full)
  ) else $error("free_list: retire push while full");
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic against a queue model.
// Recovery scenarios are compiled only when FL_BRANCH_RECOVERY_EN is defined.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       dispatch_en;
  logic       retire_en;
  logic [5:0] retire_reg;
  logic       branch_snapshot;
  logic       branch_recover;
  logic [5:0] free_reg_out;
  logic       free_reg_valid;
  logic [5:0] free_cnt;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;

  // Model: every tag ever made free, in order; tags before index 'popped' are consumed.
  int hist[$];
  int popped;
  int snap_idx;

  free_list dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .dispatch_en    (dispatch_en),
    .retire_en      (retire_en),
    .retire_reg     (retire_reg),
`ifdef FL_BRANCH_RECOVERY_EN
    .branch_snapshot(branch_snapshot),
    .branch_recover (branch_recover),
`endif
    .free_reg_out   (free_reg_out),
    .free_reg_valid (free_reg_valid),
    .free_cnt       (free_cnt),
    .empty          (empty),
    .full           (full)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 32; i++) hist.push_back(32 + i);
    popped   = 0;
    snap_idx = 0;
  endtask

  task automatic drive_idle();
    enable          = 1'b0;
    dispatch_en     = 1'b0;
    retire_en       = 1'b0;
    retire_reg      = '0;
    branch_snapshot = 1'b0;
    branch_recover  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; the model advances by the same rules, outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic en, input logic dis, input logic ret, input int r,
                       input logic snap, input logic rec);
    int  cnt;
    int  old_popped;
    bit  pop;
    bit  push;
    enable          = en;
    dispatch_en     = dis;
    retire_en       = ret;
    retire_reg      = 6'(r);
    branch_snapshot = snap;
    branch_recover  = rec;
    cnt        = hist.size() - popped;
    old_popped = popped;
    pop  = en && dis && (cnt > 0);
    push = en && ret && (cnt < 32);
`ifdef FL_BRANCH_RECOVERY_EN
    if (en && rec)       popped = snap_idx;
    else if (pop)        popped = old_popped + 1;
    if (en && snap && !rec) snap_idx = pop ? old_popped + 1 : old_popped;
`else
    if (pop) popped = old_popped + 1;
`endif
    if (push) hist.push_back(r);
    @(posedge clock);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_reg_out !== 6'd32) begin errors++; $display("[TB] FAIL reset_out: got %0d expected 32", free_reg_out); end
    checks++; if (free_cnt !== 6'd32) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 32", free_cnt); end
    checks++; if (full !== 1'b1 || empty !== 1'b0 || free_reg_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_flags: got full=%b empty=%b valid=%b expected 1 0 1", full, empty, free_reg_valid);
    end
  endtask

  task automatic test_dispatch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (free_reg_out !== 6'(32 + i)) begin errors++; $display("[TB] FAIL dispatch_out%0d: got %0d expected %0d", i, free_reg_out, 32 + i); end
      cycle(1, 1, 0, 0, 0, 0);
    end
    checks++; if (free_reg_out !== 6'd35) begin errors++; $display("[TB] FAIL dispatch_out3: got %0d expected 35", free_reg_out); end
    checks++; if (free_cnt !== 6'd29) begin errors++; $display("[TB] FAIL dispatch_cnt: got %0d expected 29", free_cnt); end
  endtask

  task automatic test_drain_no_bypass();
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1, 1, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1 || free_reg_valid !== 1'b0 || free_cnt !== 6'd0) begin
      errors++; $display("[TB] FAIL drain: got empty=%b valid=%b cnt=%0d expected 1 0 0", empty, free_reg_valid, free_cnt);
    end
    cycle(1, 1, 1, 5, 0, 0);
    checks++; if (free_cnt !== 6'd1) begin errors++; $display("[TB] FAIL nobypass_cnt: got %0d expected 1", free_cnt); end
    checks++; if (free_reg_out !== 6'd5 || free_reg_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL nobypass_out: got %0d valid=%b expected 5 valid=1", free_reg_out, free_reg_valid);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 22; i++) cycle(1, 1, 0, 0, 0, 0);
    checks++; if (free_cnt !== 6'd10) begin errors++; $display("[TB] FAIL simul_pre_cnt: got %0d expected 10", free_cnt); end
    cycle(1, 1, 1, 9, 0, 0);
    checks++; if (free_cnt !== 6'd10) begin errors++; $display("[TB] FAIL simul_cnt: got %0d expected 10", free_cnt); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (free_reg_out !== 6'(hist[popped])) begin errors++; $display("[TB] FAIL simul_seq%0d: got %0d expected %0d", i, free_reg_out, hist[popped]); end
      cycle(1, 1, 0, 0, 0, 0);
    end
    checks++; if (free_reg_out !== 6'd9 || free_cnt !== 6'd1) begin
      errors++; $display("[TB] FAIL simul_tag9: got out=%0d cnt=%0d expected 9 1", free_reg_out, free_cnt);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 11, 1, 1);
      checks++; if (free_reg_out !== 6'd37 || free_cnt !== 6'd27 || full !== 1'b0 || empty !== 1'b0) begin
        errors++; $display("[TB] FAIL hold%0d: got out=%0d cnt=%0d full=%b empty=%b expected 37 27 0 0", i, free_reg_out, free_cnt, full, empty);
      end
    end
  endtask

  task automatic test_push_full();
    do_reset();
    cycle(1, 0, 1, 7, 0, 0);
    checks++; if (free_cnt !== 6'd32 || free_reg_out !== 6'd32) begin
      errors++; $display("[TB] FAIL push_full: got cnt=%0d out=%0d expected 32 32", free_cnt, free_reg_out);
    end
    for (int i = 0; i < 31; i++) cycle(1, 1, 0, 0, 0, 0);
    checks++; if (free_reg_out !== 6'd63 || free_cnt !== 6'd1) begin
      errors++; $display("[TB] FAIL push_full_tail: got out=%0d cnt=%0d expected 63 1", free_reg_out, free_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, (i % 2) == 1, 3 + i, 0, 0);
    enable      = 1'b1;
    dispatch_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (free_reg_out !== 6'd32 || free_cnt !== 6'd32 || full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset: got out=%0d cnt=%0d full=%b empty=%b expected 32 32 1 0", free_reg_out, free_cnt, full, empty);
    end
    drive_idle();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 63)), 0, 0);
      exp_cnt = hist.size() - popped;
      checks++; if (free_cnt !== 6'(exp_cnt) || empty !== (exp_cnt == 0) || full !== (exp_cnt == 32) || free_reg_valid !== (exp_cnt != 0)) begin
        errors++; $display("[TB] FAIL rand_cnt%0d: got cnt=%0d empty=%b full=%b valid=%b expected cnt=%0d", i, free_cnt, empty, full, free_reg_valid, exp_cnt);
      end
      if (exp_cnt > 0) begin
        checks++; if (free_reg_out !== 6'(hist[popped])) begin errors++; $display("[TB] FAIL rand_out%0d: got %0d expected %0d", i, free_reg_out, hist[popped]); end
      end
    end
  endtask

`ifdef FL_BRANCH_RECOVERY_EN
  task automatic test_branch_recovery();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);
    checks++; if (free_reg_out !== 6'd36 || free_cnt !== 6'd28) begin
      errors++; $display("[TB] FAIL br_pre: got out=%0d cnt=%0d expected 36 28", free_reg_out, free_cnt);
    end
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 7, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    checks++; if (free_reg_out !== 6'd36 || free_cnt !== 6'd29) begin
      errors++; $display("[TB] FAIL br_recover: got out=%0d cnt=%0d expected 36 29", free_reg_out, free_cnt);
    end
    cycle(1, 1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 1);
    checks++; if (free_reg_out !== 6'd37) begin errors++; $display("[TB] FAIL br_snap_pop: got %0d expected 37", free_reg_out); end
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    checks++; if (free_reg_out !== 6'(hist[popped]) || free_reg_out !== 6'd37) begin
      errors++; $display("[TB] FAIL br_snap_hold: got %0d expected 37", free_reg_out);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_dispatch();
    test_drain_no_bypass();
    test_simultaneous();
    test_enable_hold();
`ifndef DEBUG
    test_push_full();
`endif
    test_reset_mid_run();
`ifdef FL_BRANCH_RECOVERY_EN
    test_branch_recovery();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
